fpu_addsub_sequencer: RTL and testbench
=======================================

Name: fpu_addsub_sequencer

Overview:
- Upstream issue/collect stage for float_adder_subtractor.
- Accepts operand requests through a valid/ready handshake and buffers them in a small FIFO.
- Drives the core's one-cycle load strobe, waits for the core's valid, and returns results in order, with a tag, through a second valid/ready handshake.
- A watchdog converts a hung core operation into a flagged NaN result so the pipeline never deadlocks.

Parameters:
- PRECISION, 32: operand width; 32 or 64 only, matching the core.
- FIFO_DEPTH, 4: request FIFO entries; power of two, at least 2.
- TAG_W, 4: width of the request tag carried to the result.
- TIMEOUT, 127: maximum cycles in WAIT before the watchdog fires.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  FIFO can accept; equals count != FIFO_DEPTH.
- in_a  in  PRECISION  operand A.
- in_b  in  PRECISION  operand B.
- in_op  in  1  0 = add, 1 = subtract (A-B).
- in_tag  in  TAG_W  request tag.
- core_inA  out  PRECISION  registered operand A to the core.
- core_inB  out  PRECISION  registered operand B to the core.
- core_op  out  1  registered op to the core.
- core_load  out  1  load strobe to the core; high only in ISSUE.
- core_out  in  PRECISION  core result.
- core_valid  in  1  core result valid.
- res_valid  out  1  result present.
- res_ready  in  1  consumer accepts the result.
- res_data  out  PRECISION  result word.
- res_tag  out  TAG_W  tag of the request that produced res_data.
- res_timeout  out  1  result was produced by the watchdog.
- busy  out  1  state != IDLE or count != 0.
- count  out  clog2(FIFO_DEPTH+1)  FIFO occupancy.

Behaviour:
Reset
- rst=1 forces the following immediately, with no clock required: state=IDLE, FIFO pointers and count=0, res_valid=0, res_data=0, res_tag=0, res_timeout=0, core_inA/B=0, core_op=0, core_load=0, timer=0.

FIFO
- Push on in_valid && in_ready; entries are {a, b, op, tag}.
- Pop happens only on the FSM transition into ISSUE.
- Push and pop in the same cycle are both honoured; count is unchanged.
- in_ready is 0 when full, even if a pop occurs that cycle (no bypass).
- Read and write pointers wrap modulo FIFO_DEPTH.

FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE: if count>0, pop the head into core_inA/B/op and an internal tag register, then go to ISSUE.
- ISSUE:
  - core_load=1 for exactly this one cycle.
  - Timer cleared to 0; go to WAIT.
- WAIT:
  - Timer increments each cycle.
  - If core_valid=1: res_data<=core_out, res_tag<=tag, res_timeout<=0, res_valid<=1, go to HOLD.
  - Else if timer==TIMEOUT: res_data<=canonical NaN, res_tag<=tag, res_timeout<=1, res_valid<=1, go to HOLD.
  - Canonical NaN is sign 0, exponent all ones, mantissa all ones: 0x7FFFFFFF for PRECISION=32, 0x7FFFFFFFFFFFFFFF for PRECISION=64.
  - core_valid takes priority over the timeout in the same cycle.
- HOLD:
  - res_valid, res_data, res_tag and res_timeout are held stable until res_ready.
  - On res_ready: res_valid<=0. If count>0, pop and go straight to ISSUE; else go to IDLE.

Core interaction rules
- The core clears its valid at the edge that samples load, so core_valid is trustworthy from the first WAIT cycle.
- core_valid is ignored in every state except WAIT, including stale-high valid after reset; the core itself has no reset.
- core_inA/B/op change only when popping; they are stable through ISSUE and WAIT.

Latency and throughput
- Minimum latency, accept edge to res_valid=1, is 4 cycles, reached when the core takes the special/neglect path (valid one cycle after load).
- General latency is 4 + (core cycles beyond one).
- One operation is in flight at a time; results are returned in request order.

Reset mid-operation
- The in-flight op and all queued requests are discarded; no result is produced for them.

Test Plan:
- Add: in_a=0x3F800000, in_b=0x40000000, op=0, tag=3, res_ready=1. Required: core_load high exactly 1 cycle; res_data=0x40400000, res_tag=3, res_timeout=0.
- Subtract: in_a=0x40400000, in_b=0x3F800000, op=1, tag=5. Required: res_data=0x40000000, res_tag=5.
- Backpressure: res_ready=0, push 6 requests with tags 0..5 back-to-back. Required: tag 0 issues to the core; tags 1–4 are accepted; in_ready=0 while tag 5 is offered, and count=4. After res_ready=1, results arrive in tag order 0..5 with no loss or duplication.
- Special latency: in_a=0x7F800000, in_b=0xFF800000, op=0, pushed into an empty idle block. Required: res_data=0x7FFFFFFF and res_valid rises exactly 4 cycles after the accept edge.
- Watchdog: stub the core with core_valid held 0 and TIMEOUT=127. Required: res_valid=1 with res_timeout=1 and res_data=0x7FFFFFFF after 128 WAIT cycles. The next request, with a real core, completes normally with res_timeout=0.
- Async reset: assert rst mid-WAIT with 2 requests queued and core_valid=1 stale. Required: res_valid=0, count=0, in_ready=1 and core_load=0 immediately; no result appears until a new request is pushed.

Source files
------------

// File: rtl/fpu_addsub_sequencer.sv
// Issue/collect sequencer for float_adder_subtractor: request FIFO, one-op-in-flight
// core handshake with watchdog, and an in-order tagged result port.
module fpu_addsub_sequencer #(
   parameter int PRECISION  = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int TAG_W      = 4,
   parameter int TIMEOUT    = 127
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [PRECISION-1:0]               in_a,
   input  logic [PRECISION-1:0]               in_b,
   input  logic                               in_op,
   input  logic [TAG_W-1:0]                   in_tag,
   output logic [PRECISION-1:0]               core_inA,
   output logic [PRECISION-1:0]               core_inB,
   output logic                               core_op,
   output logic                               core_load,
   input  logic [PRECISION-1:0]               core_out,
   input  logic                               core_valid,
   output logic                               res_valid,
   input  logic                               res_ready,
   output logic [PRECISION-1:0]               res_data,
   output logic [TAG_W-1:0]                   res_tag,
   output logic                               res_timeout,
   output logic                               busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    count
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   // Canonical NaN: sign clear, exponent and mantissa all ones.
   localparam logic [PRECISION-1:0] CANON_NAN = {1'b0, {(PRECISION-1){1'b1}}};

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

   state_t                r_state, w_state_next;
   logic [PRECISION-1:0]  r_fifo_a   [FIFO_DEPTH];
   logic [PRECISION-1:0]  r_fifo_b   [FIFO_DEPTH];
   logic                  r_fifo_op  [FIFO_DEPTH];
   logic [TAG_W-1:0]      r_fifo_tag [FIFO_DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0]      r_count;
   logic [TMR_W-1:0]      r_timer;
   logic [PRECISION-1:0]  r_core_a, r_core_b;
   logic                  r_core_op;
   logic [TAG_W-1:0]      r_tag;
   logic                  r_res_valid, r_res_timeout;
   logic [PRECISION-1:0]  r_res_data;
   logic [TAG_W-1:0]      r_res_tag;
   logic                  w_push, w_pop, w_full, w_timer_hit;

   assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_push      = in_valid && !w_full;
   assign w_timer_hit = (r_timer == TMR_W'(TIMEOUT));

   assign in_ready    = !w_full;
   assign count       = r_count;
   assign busy        = (r_state != IDLE) || (r_count != '0);
   assign core_load   = (r_state == ISSUE);
   assign core_inA    = r_core_a;
   assign core_inB    = r_core_b;
   assign core_op     = r_core_op;
   assign res_valid   = r_res_valid;
   assign res_data    = r_res_data;
   assign res_tag     = r_res_tag;
   assign res_timeout = r_res_timeout;

   // Storage carries no reset; validity is tracked entirely by the pointers and count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_a[r_wr_ptr]   <= in_a;
         r_fifo_b[r_wr_ptr]   <= in_b;
         r_fifo_op[r_wr_ptr]  <= in_op;
         r_fifo_tag[r_wr_ptr] <= in_tag;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_pop        = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_count != '0) begin
               w_pop        = 1'b1;
               w_state_next = ISSUE;
            end
         end
         ISSUE: w_state_next = WAIT;
         WAIT: begin
            if (core_valid || w_timer_hit) w_state_next = HOLD;
         end
         HOLD: begin
            if (res_ready) begin
               if (r_count != '0) begin
                  w_pop        = 1'b1;
                  w_state_next = ISSUE;
               end else begin
                  w_state_next = IDLE;
               end
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Core operands, watchdog timer and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_core_a      <= '0;
         r_core_b      <= '0;
         r_core_op     <= 1'b0;
         r_tag         <= '0;
         r_timer       <= '0;
         r_res_valid   <= 1'b0;
         r_res_data    <= '0;
         r_res_tag     <= '0;
         r_res_timeout <= 1'b0;
      end else begin
         if (w_pop) begin
            r_core_a  <= r_fifo_a[r_rd_ptr];
            r_core_b  <= r_fifo_b[r_rd_ptr];
            r_core_op <= r_fifo_op[r_rd_ptr];
            r_tag     <= r_fifo_tag[r_rd_ptr];
         end
         case (r_state)
            ISSUE: r_timer <= '0;
            WAIT: begin
               r_timer <= r_timer + 1'b1;
               if (core_valid) begin
                  r_res_data    <= core_out;
                  r_res_tag     <= r_tag;
                  r_res_timeout <= 1'b0;
                  r_res_valid   <= 1'b1;
               end else if (w_timer_hit) begin
                  r_res_data    <= CANON_NAN;
                  r_res_tag     <= r_tag;
                  r_res_timeout <= 1'b1;
                  r_res_valid   <= 1'b1;
               end
            end
            HOLD: begin
               if (res_ready) r_res_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_addsub_sequencer.sv
// Scoreboard bench for fpu_addsub_sequencer with a behavioural stub of the FP core.
module tb_fpu_addsub_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_op;
   logic [31:0] in_a, in_b;
   logic [3:0]  in_tag;
   logic [31:0] core_inA, core_inB, core_out;
   logic        core_op, core_load, core_valid;
   logic        res_valid, res_ready, res_timeout, busy;
   logic [31:0] res_data;
   logic [3:0]  res_tag;
   logic [2:0]  count;

   always #5 clk = ~clk;

   fpu_addsub_sequencer #(.PRECISION(32), .FIFO_DEPTH(4), .TAG_W(4), .TIMEOUT(127)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .in_op(in_op), .in_tag(in_tag),
      .core_inA(core_inA), .core_inB(core_inB), .core_op(core_op), .core_load(core_load),
      .core_out(core_out), .core_valid(core_valid),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_tag(res_tag), .res_timeout(res_timeout), .busy(busy), .count(count)
   );

   typedef struct {
      logic [31:0] data;
      logic [3:0]  tag;
      logic        tmo;
      int          lat;
      int          acc;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        op;
   } iss_t;

   exp_t exp_q[$];
   iss_t iss_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Backpressure vectors: k.0 + 1.0 = (k+1).0 for k = 1..6
   logic [31:0] bp_a [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                             32'h40800000, 32'h40A00000, 32'h40C00000};
   logic [31:0] bp_r [6] = '{32'h40000000, 32'h40400000, 32'h40800000,
                             32'h40A00000, 32'h40C00000, 32'h40E00000};

   // Stub core: lookup of hand-computed sums; 1-cycle special path for Inf/NaN operand A.
   logic [31:0] sc_res   = 32'h0;
   logic        sc_valid = 1'b0;
   logic        sc_busy  = 1'b0;
   int          sc_cnt   = 0;
   logic        core_dead = 1'b0;
   logic        stale     = 1'b0;

   assign core_out   = sc_res;
   assign core_valid = sc_valid | stale;

   function automatic logic [31:0] core_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic op);
      if (!op && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
      if ( op && a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000;
      if (!op && a == 32'h7F800000 && b == 32'hFF800000) return 32'h7FFFFFFF;
      if (!op && a == 32'h40200000 && b == 32'h3F000000) return 32'h40400000;
      if (!op && a == 32'h3FC00000 && b == 32'h3FC00000) return 32'h40400000;
      for (int k = 0; k < 6; k++)
         if (!op && a == bp_a[k] && b == 32'h3F800000) return bp_r[k];
      return 32'hDEADBEEF;
   endfunction

   always @(posedge clk) begin
      if (core_load) begin
         sc_valid <= 1'b0;
         sc_res   <= core_fn(core_inA, core_inB, core_op);
         sc_cnt   <= (core_inA[30:23] == 8'hFF) ? 1 : 3;
         sc_busy  <= 1'b1;
      end else if (sc_busy && !core_dead) begin
         if (sc_cnt == 1) begin
            sc_valid <= 1'b1;
            sc_busy  <= 1'b0;
         end
         sc_cnt <= sc_cnt - 1;
      end
   end

   // Monitor: issue checks on core_load, latency on res_valid rise, results on handshake.
   logic prev_rv   = 1'b0;
   logic prev_load = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         prev_rv   <= 1'b0;
         prev_load <= 1'b0;
      end else begin
         if (prev_load) begin
            n_tests++;
            if (core_load !== 1'b0) begin
               n_fail++;
               $display("[TB] FAIL load_1cyc: core_load=%b required 0 on second cycle", core_load);
            end
         end
         if (core_load && !prev_load) begin
            n_tests++;
            if (iss_q.size() == 0) begin
               n_fail++;
               $display("[TB] FAIL unexpected_load: core_load with no queued request");
            end else begin
               iss_t e;
               e = iss_q.pop_front();
               if (core_inA !== e.a || core_inB !== e.b || core_op !== e.op) begin
                  n_fail++;
                  $display("[TB] FAIL issue: got A=%h B=%h op=%b required A=%h B=%h op=%b",
                           core_inA, core_inB, core_op, e.a, e.b, e.op);
               end else
                  $display("[TB] issue A=%h B=%h op=%b", core_inA, core_inB, core_op);
            end
         end
         if (res_valid && !prev_rv && exp_q.size() > 0 && exp_q[0].lat >= 0) begin
            n_tests++;
            if (cyc - exp_q[0].acc != exp_q[0].lat) begin
               n_fail++;
               $display("[TB] FAIL latency: got %0d cycles required %0d",
                        cyc - exp_q[0].acc, exp_q[0].lat);
            end else
               $display("[TB] latency %0d cycles", cyc - exp_q[0].acc);
         end
         if (res_valid && res_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("[TB] FAIL unexpected_result: data=%h tag=%0d with nothing outstanding",
                        res_data, res_tag);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (res_data !== e.data || res_tag !== e.tag || res_timeout !== e.tmo) begin
                  n_fail++;
                  $display("[TB] FAIL result: got data=%h tag=%0d tmo=%b required data=%h tag=%0d tmo=%b",
                           res_data, res_tag, res_timeout, e.data, e.tag, e.tmo);
               end else
                  $display("[TB] result data=%h tag=%0d tmo=%b", res_data, res_tag, res_timeout);
            end
         end
         prev_rv   <= res_valid;
         prev_load <= core_load;
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
      n_tests++;
      if (got !== req) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h required %h", name, got, req);
      end else
         $display("[TB] check %s = %h", name, got);
   endtask

   // Called at a negedge; returns at the negedge right after the accepting edge.
   task automatic push(input logic [31:0] a, input logic [31:0] b, input logic op,
                       input logic [3:0] tag, input logic [31:0] exp_data,
                       input logic exp_tmo, input int lat);
      int   w;
      exp_t e;
      iss_t s;
      in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_tag = tag;
      w = 0;
      while (!in_ready && w < 500) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) begin
         n_tests++;
         n_fail++;
         $display("[TB] FAIL push_timeout: tag %0d never accepted", tag);
         in_valid = 1'b0;
         return;
      end
      @(negedge clk);
      in_valid = 1'b0;
      e.data = exp_data; e.tag = tag; e.tmo = exp_tmo; e.lat = lat; e.acc = cyc;
      exp_q.push_back(e);
      s.a = a; s.b = b; s.op = op;
      iss_q.push_back(s);
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 2000) begin
         @(negedge clk);
         w++;
      end
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("[TB] FAIL drain_timeout: %0d results outstanding", exp_q.size());
         exp_q.delete();
         iss_q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int hi;
      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; in_tag = '0;
      res_ready = 1'b1;
      #1;
      check("rst_res_valid", {31'b0, res_valid}, 32'h0);
      check("rst_res_data", res_data, 32'h0);
      check("rst_core_load", {31'b0, core_load}, 32'h0);
      check("rst_count", {29'b0, count}, 32'h0);
      check("rst_in_ready", {31'b0, in_ready}, 32'h1);
      check("rst_busy", {31'b0, busy}, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // 1.0 + 2.0 = 3.0, then 3.0 - 1.0 = 2.0
      push(32'h3F800000, 32'h40000000, 1'b0, 4'd3, 32'h40400000, 1'b0, -1);
      drain();
      push(32'h40400000, 32'h3F800000, 1'b1, 4'd5, 32'h40000000, 1'b0, -1);
      drain();

      // Backpressure: tag 0 in flight, tags 1..4 fill the FIFO, tag 5 must stall
      res_ready = 1'b0;
      for (int i = 0; i < 5; i++)
         push(bp_a[i], 32'h3F800000, 1'b0, 4'(i), bp_r[i], 1'b0, -1);
      in_valid = 1'b1; in_a = bp_a[5]; in_b = 32'h3F800000; in_op = 1'b0; in_tag = 4'd5;
      repeat (6) @(negedge clk);
      check("bp_in_ready", {31'b0, in_ready}, 32'h0);
      check("bp_count", {29'b0, count}, 32'h4);
      res_ready = 1'b1;
      push(bp_a[5], 32'h3F800000, 1'b0, 4'd5, bp_r[5], 1'b0, -1);
      drain();

      // +Inf + -Inf through the special path: 4-cycle latency
      push(32'h7F800000, 32'hFF800000, 1'b0, 4'd6, 32'h7FFFFFFF, 1'b0, 4);
      drain();

      // Hung core: watchdog fires after 2 + 128 cycles
      core_dead = 1'b1;
      push(32'h3F800000, 32'h3F800000, 1'b0, 4'd7, 32'h7FFFFFFF, 1'b1, 130);
      drain();
      core_dead = 1'b0;
      push(32'h40200000, 32'h3F000000, 1'b0, 4'd8, 32'h40400000, 1'b0, -1);
      drain();

      // Async reset mid-WAIT with two requests queued and a stale core_valid
      core_dead = 1'b1;
      push(32'h3F800000, 32'h40000000, 1'b0, 4'd9, 32'h40400000, 1'b0, -1);
      push(32'h3F800000, 32'h40000000, 1'b0, 4'd10, 32'h40400000, 1'b0, -1);
      push(32'h3F800000, 32'h40000000, 1'b0, 4'd11, 32'h40400000, 1'b0, -1);
      repeat (3) @(negedge clk);
      check("pre_rst_count", {29'b0, count}, 32'h2);
      rst = 1'b1;
      stale = 1'b1;
      #1;
      exp_q.delete();
      iss_q.delete();
      check("arst_res_valid", {31'b0, res_valid}, 32'h0);
      check("arst_count", {29'b0, count}, 32'h0);
      check("arst_in_ready", {31'b0, in_ready}, 32'h1);
      check("arst_core_load", {31'b0, core_load}, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      core_dead = 1'b0;
      hi = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (res_valid) hi++;
      end
      check("post_rst_no_result", hi, 32'h0);
      check("post_rst_busy", {31'b0, busy}, 32'h0);
      stale = 1'b0;
      @(negedge clk);
      push(32'h3FC00000, 32'h3FC00000, 1'b0, 4'd12, 32'h40400000, 1'b0, -1);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end

endmodule
